// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART echo path.
//   CLK_FREQ / BAUD  - system clock and line rate.
//   BIT_CYCLES       - sclk cycles per UART bit.
//   GAP_DEFAULT      - sclk cycles per 11-bit frame, used as the default
//                      spacing between transmitter start strobes.
//   pace_state_e     - state encoding of the transmit pacing FSM.
package uart_pkg;

    localparam int unsigned CLK_FREQ    = 32'd50_000_000;
    localparam int unsigned BAUD        = 32'd9600;
    localparam int unsigned BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int unsigned FRAME_BITS  = 32'd11;
    localparam int unsigned GAP_DEFAULT = FRAME_BITS * BIT_CYCLES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRIG = 2'd1,
        ST_WAIT = 2'd2
    } pace_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with an occupancy counter.
//   sclk, reset        - clock, asynchronous active-high reset.
//   wr_en, wr_data     - push request and data; a push while full is only
//                        honoured when a pop happens in the same cycle.
//   rd_en, rd_data     - pop request; rd_data always shows the head entry.
//   count, full, empty - occupancy (0..DEPTH) and its decoded flags.
// Storage is not reset: the pointers and count alone define the contents.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     sclk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(32'd1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(32'd1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr_s;
    logic             do_rd_s;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == {(AW+1){1'b0}});
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Qualify requests so the pointers can never run past each other.
    assign do_rd_s = rd_en & ~empty;
    assign do_wr_s = wr_en & (~full | do_rd_s);

    // Data storage, written at the write pointer.
    always_ff @(posedge sclk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffers bytes from a UART receiver and replays them to a
// UART transmitter, spacing transmit starts GAP_CYCLES sclk cycles apart.
//   sclk, reset - clock, asynchronous active-high reset.
//   rx_data     - received byte, valid while po_flag=1.
//   po_flag     - one-cycle strobe marking a new received byte.
//   tx_data     - byte for the transmitter (registered, held until next pop).
//   tx_trig     - one-cycle transmitter start strobe (registered).
//   fifo_count  - bytes currently buffered (0..DEPTH).
//   overflow    - sticky: a received byte was dropped because the FIFO was full.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GAP_CYCLES = GAP_DEFAULT
) (
    input  logic                    sclk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    po_flag,
    output logic [7:0]              tx_data,
    output logic                    tx_trig,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 32'd1);
    // WAIT covers GAP_CYCLES-2 cycles; IDLE (pop) and TRIG supply the rest.
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 32'd2);
    localparam logic [GW-1:0] GAP_ONE  = GW'(32'd1);
    localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};

    pace_state_e     state_q;
    pace_state_e     state_d;
    logic [GW-1:0]   gap_q;
    logic [GW-1:0]   gap_d;
    logic [7:0]      tx_data_q;
    logic [7:0]      tx_data_d;
    logic            tx_trig_q;
    logic            tx_trig_d;
    logic            overflow_q;
    logic            overflow_d;

    logic            rd_en_s;
    logic            wr_en_s;
    logic [7:0]      fifo_rd_data_s;
    logic [$clog2(DEPTH):0] fifo_count_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;

    // A full FIFO still accepts a byte when the head is popped that cycle.
    assign wr_en_s    = po_flag & (~fifo_full_s | rd_en_s);
    assign overflow_d = overflow_q | (po_flag & fifo_full_s & ~rd_en_s);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sclk    (sclk),
        .reset   (reset),
        .wr_en   (wr_en_s),
        .wr_data (rx_data),
        .rd_en   (rd_en_s),
        .rd_data (fifo_rd_data_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Pacing FSM state register.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pacing FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_TRIG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIG: begin
                // With GAP_CYCLES=2 there is no waiting time left at all.
                if (GAP_LOAD != GAP_ZERO) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (gap_q <= GAP_ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pacing FSM outputs: pop request and next values of the output registers.
    always_comb begin
        rd_en_s   = 1'b0;
        tx_data_d = tx_data_q;
        tx_trig_d = 1'b0;
        gap_d     = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    rd_en_s   = 1'b1;
                    tx_data_d = fifo_rd_data_s;
                    tx_trig_d = 1'b1;
                end else begin
                    rd_en_s   = 1'b0;
                end
            end
            ST_TRIG: begin
                gap_d = GAP_LOAD;
            end
            ST_WAIT: begin
                if (gap_q != GAP_ZERO) begin
                    gap_d = gap_q - GAP_ONE;
                end else begin
                    gap_d = GAP_ZERO;
                end
            end
            default: begin
                gap_d = GAP_ZERO;
            end
        endcase
    end

    // Registered outputs, gap counter and sticky overflow flag.
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            tx_data_q  <= 8'h00;
            tx_trig_q  <= 1'b0;
            gap_q      <= GAP_ZERO;
            overflow_q <= 1'b0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_trig_q  <= tx_trig_d;
            gap_q      <= gap_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_trig    = tx_trig_q;
    assign fifo_count = fifo_count_s;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Testbench for uart_echo_fifo. A small instance (DEPTH=4, GAP_CYCLES=8) is
// driven by directed and random stimulus and compared against a queue-based
// reference model; a default-parameter instance checks the full-size gap.
module tb_uart_echo_fifo;

    localparam int DEPTH = 4;
    localparam int GAP   = 8;

    typedef struct {
        logic [7:0] b;
        int         c;
    } exp_t;

    logic       sclk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       po_flag;
    logic [7:0] tx_data;
    logic       tx_trig;
    logic [2:0] fifo_count;
    logic       overflow;

    logic       b_reset;
    logic [7:0] b_rx;
    logic       b_po;
    logic [7:0] b_tx;
    logic       b_trig;
    logic [4:0] b_count;
    logic       b_ovf;
    bit         big_done = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model state
    logic [7:0] mq[$];
    exp_t       sb_q[$];
    int         m_next_pop = 0;
    bit         m_ovf      = 1'b0;
    logic [7:0] last_tx    = 8'h00;
    bit         prev_trig  = 1'b0;

    always #5 sclk = ~sclk;

    always @(posedge sclk) cyc <= cyc + 1;

    uart_echo_fifo #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) u_dut (
        .sclk       (sclk),
        .reset      (reset),
        .rx_data    (rx_data),
        .po_flag    (po_flag),
        .tx_data    (tx_data),
        .tx_trig    (tx_trig),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    uart_echo_fifo u_big (
        .sclk       (sclk),
        .reset      (b_reset),
        .rx_data    (b_rx),
        .po_flag    (b_po),
        .tx_data    (b_tx),
        .tx_trig    (b_trig),
        .fifo_count (b_count),
        .overflow   (b_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: per cycle, decide pop/accept from queue size and pacing time.
    always @(negedge sclk) begin : model
        bit pop;
        bit acc;
        if (reset) begin
            check("rst_count", 32'(fifo_count), 32'd0);
            check("rst_overflow", 32'(overflow), 32'd0);
            check("rst_trig", 32'(tx_trig), 32'd0);
            check("rst_txdata", 32'(tx_data), 32'd0);
            mq.delete();
            sb_q.delete();
            m_ovf      = 1'b0;
            m_next_pop = 0;
        end else begin
            check("count", 32'(fifo_count), 32'(mq.size()));
            check("overflow", 32'(overflow), 32'(m_ovf));
            pop = (mq.size() > 0) && (cyc >= m_next_pop);
            acc = po_flag && ((mq.size() < DEPTH) || pop);
            if (po_flag && !acc) m_ovf = 1'b1;
            if (pop) begin
                exp_t e;
                e.b = mq.pop_front();
                e.c = cyc + 1;
                sb_q.push_back(e);
                m_next_pop = cyc + GAP;
            end
            if (acc) mq.push_back(rx_data);
        end
    end

    // Monitor: consume an expected byte on every tx_trig and check hold/spacing.
    always @(negedge sclk) begin : monitor
        exp_t e;
        if (reset) begin
            last_tx   = 8'h00;
            prev_trig = 1'b0;
        end else begin
            if (tx_trig) begin
                check("trig_back_to_back", 32'(prev_trig), 32'd0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_trig: got tx_trig=1 data %0h expected no pulse (cycle %0d)", tx_data, cyc);
                end else begin
                    e = sb_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(e.b));
                    check("trig_cycle", 32'(cyc), 32'(e.c));
                    last_tx = e.b;
                end
            end else begin
                check("tx_hold", 32'(tx_data), 32'(last_tx));
                if (sb_q.size() > 0) begin
                    check("trig_missed", 32'(sb_q[0].c < cyc), 32'd0);
                    if (sb_q[0].c < cyc) void'(sb_q.pop_front());
                end
            end
            prev_trig = tx_trig;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        po_flag = 1'b1;
        rx_data = b;
        step(1);
        po_flag = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic pulse_reset(input int n);
        reset   = 1'b1;
        po_flag = 1'b0;
        step(n);
        reset   = 1'b0;
    endtask

    // Main sequence on the small instance.
    initial begin : main
        int n;
        int rate;
        reset   = 1'b1;
        po_flag = 1'b0;
        rx_data = 8'h00;
        step(3);
        reset = 1'b0;
        step(2);

        // single byte: trig two cycles after the strobe
        send(8'hA5);
        @(negedge sclk);
        check("single_c1_trig", 32'(tx_trig), 32'd0);
        check("single_c1_count", 32'(fifo_count), 32'd1);
        @(negedge sclk);
        check("single_c2_trig", 32'(tx_trig), 32'd1);
        check("single_c2_data", 32'(tx_data), 32'hA5);
        check("single_c2_count", 32'(fifo_count), 32'd0);
        @(posedge sclk);
        #1;
        step(12);

        // three back-to-back bytes
        send(8'h01);
        send(8'h02);
        send(8'h03);
        step(30);

        // overfill while the FSM is waiting
        send(8'h0F);
        step(2);
        for (int i = 0; i < 6; i++) send(8'(8'h10 + i));
        @(negedge sclk);
        check("overfill_count", 32'(fifo_count), 32'd4);
        check("overfill_flag", 32'(overflow), 32'd1);
        @(posedge sclk);
        #1;
        step(50);

        // write coincident with a pop while full
        pulse_reset(1);
        step(2);
        send(8'h20);
        step(2);
        for (int i = 1; i <= 4; i++) send(8'(8'h20 + i));
        step(2);
        send(8'h25);
        @(negedge sclk);
        check("coinc_count", 32'(fifo_count), 32'd4);
        check("coinc_overflow", 32'(overflow), 32'd0);
        @(posedge sclk);
        #1;
        step(50);

        // reset during WAIT with three bytes queued
        for (int i = 0; i < 4; i++) send(8'(8'h30 + i));
        pulse_reset(1);
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            check("post_reset_trig", 32'(tx_trig), 32'd0);
        end
        @(posedge sclk);
        #1;

        // random traffic with varying load and occasional resets
        for (int blk = 0; blk < 5; blk++) begin
            rate = (blk == 0) ? 5 : (blk == 1) ? 15 : (blk == 2) ? 30 : (blk == 3) ? 60 : 100;
            for (int k = 0; k < 300; k++) begin
                if ($urandom_range(0, 399) == 0) begin
                    pulse_reset($urandom_range(1, 2));
                end else begin
                    po_flag = ($urandom_range(0, 99) < rate);
                    rx_data = 8'($urandom);
                    step(1);
                end
            end
        end
        po_flag = 1'b0;

        n = 0;
        while ((mq.size() != 0 || sb_q.size() != 0) && n < 300) begin
            step(1);
            n++;
        end
        check("drain_empty", 32'(mq.size() + sb_q.size()), 32'd0);

        n = 0;
        while (!big_done && n < 70000) begin
            step(1);
            n++;
        end
        check("big_finished", 32'(big_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Default-parameter instance: two bytes, pulses one full frame gap apart.
    initial begin : big
        int t[2];
        logic [7:0] d[2];
        int got;
        int k;
        b_reset = 1'b1;
        b_po    = 1'b0;
        b_rx    = 8'h00;
        repeat (3) @(posedge sclk);
        #1;
        b_reset = 1'b0;
        b_po    = 1'b1;
        b_rx    = 8'h3C;
        @(posedge sclk);
        #1;
        b_rx    = 8'hC3;
        @(posedge sclk);
        #1;
        b_po    = 1'b0;
        got = 0;
        k   = 0;
        while (got < 2 && k < 60000) begin
            @(negedge sclk);
            if (b_trig) begin
                t[got] = k;
                d[got] = b_tx;
                got++;
            end
            k++;
        end
        check("big_pulses", 32'(got), 32'd2);
        if (got == 2) begin
            check("big_gap", 32'(t[1] - t[0]), 32'd57288);
            check("big_byte0", 32'(d[0]), 32'h3C);
            check("big_byte1", 32'(d[1]), 32'hC3);
        end
        check("big_count", 32'(b_count), 32'd0);
        check("big_overflow", 32'(b_ovf), 32'd0);
        big_done = 1'b1;
    end

endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, 4..256.
REQ-002 Parameter GAP_CYCLES, default 57288, sclk cycles from one tx_trig pulse to the next (11 bit-times at 50 MHz / 9600 baud); minimum 2.
REQ-003 sclk  input  1  the block's one clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver; valid only while po_flag=1.
REQ-006 po_flag  input  1  one-cycle strobe: rx_data holds a new byte.
REQ-007 tx_data  output  8  byte for the UART transmitter; registered.
REQ-008 tx_trig  output  1  one-cycle start strobe to the transmitter; registered.
REQ-009 fifo_count  output  log2(DEPTH)+1  bytes currently stored.
REQ-010 overflow  output  1  sticky: a received byte was dropped.

Function
REQ-011 SHALL buffer bytes between receiver and transmitter in arrival order (FIFO), pacing transmit starts at GAP_CYCLES intervals.
REQ-012 SHALL write rx_data into the FIFO on every sclk edge where po_flag=1 and the FIFO is not full, or is full and a read happens in the same cycle.
REQ-013 SHALL drop the byte, leave contents unchanged and set overflow=1 when po_flag=1 while full and no read occurs that cycle.
REQ-014 fifo_count SHALL increment on write-only, decrement on read-only, hold on simultaneous write+read; range 0..DEPTH.
REQ-015 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-016 Pacing FSM states: IDLE, TRIG, WAIT.
REQ-017 IDLE: if fifo_count>0, pop the head byte into tx_data and go to TRIG next cycle; else stay.
REQ-018 TRIG: tx_trig=1 for exactly this cycle, gap counter loaded with GAP_CYCLES-2, go to WAIT.
REQ-019 WAIT: decrement gap counter; at 0 return to IDLE; tx_trig=0.
REQ-020 Latency: po_flag at cycle 0 into an empty FIFO with FSM in IDLE SHALL give tx_trig=1 in cycle 2 with tx_data equal to that byte.
REQ-021 Consecutive tx_trig pulses SHALL be exactly GAP_CYCLES cycles apart while FIFO stays non-empty.
REQ-022 tx_data SHALL remain stable from the TRIG cycle until the next pop.
REQ-023 tx_trig SHALL never be asserted in two consecutive cycles.
REQ-024 Gap counter SHALL be wide enough for GAP_CYCLES with no truncation.

Reset
REQ-025 While reset=1: tx_data=8'h00, tx_trig=0, fifo_count=0, overflow=0, pointers=0, FSM=IDLE, gap counter=0.
REQ-026 Reset mid-WAIT or with FIFO non-empty SHALL discard all stored bytes; no tx_trig in the cycle after reset deasserts.
REQ-027 FIFO storage array need not be reset; only pointers and count define contents.

Structure
REQ-028 Shared package uart_pkg SHALL hold CLK_FREQ (50_000_000), BAUD (9600), derived BIT_CYCLES and the FSM state encoding.
REQ-029 One sub-module sync_fifo (parameters WIDTH, DEPTH; ports wr_en, wr_data, rd_en, rd_data, count, full, empty) holds storage and pointers; uart_echo_fifo holds the pacing FSM and overflow flag.
REQ-030 Top-level integration places the block between uart_rx outputs (rx_data, po_flag) and uart_tx inputs (tx_data, tx_trig).

Verification (DEPTH=4, GAP_CYCLES=8 unless stated)
REQ-031 Single byte 8'hA5 via po_flag at cycle 0 -> tx_trig in cycle 2 only, tx_data=8'hA5, fifo_count back to 0 at cycle 2.
REQ-032 Three back-to-back bytes 8'h01,02,03 -> tx_trig at cycles 2,10,18, tx_data in that order, no other pulses.
REQ-033 Hold FSM in WAIT, write 6 bytes 8'h10..8'h15 -> fifo_count saturates at 4, overflow=1, transmitted 10,11,12,13 (plus any byte accepted on a simultaneous pop), never 15 out of order.
REQ-034 po_flag coincident with a pop while fifo_count=4 -> byte accepted, count stays 4, overflow stays 0.
REQ-035 Assert reset for 1 cycle during WAIT with 3 bytes queued -> all outputs at reset values, no tx_trig for 20 cycles after release.
REQ-036 Default parameters, 2 bytes -> tx_trig pulses exactly 57288 cycles apart.
